// File: rtl/aq_vlsu_ld_wb_sched.sv
// Vector-load writeback scheduler: buffers align-buffer beats in a
// 3-entry FIFO and writes them to the VRF as vreg halves, in order.
module aq_vlsu_ld_wb_sched (
    input  logic        align_clk,
    input  logic        cpurst_b,
    input  logic        rtu_yy_xx_flush,
    input  logic        inst_start,
    input  logic [7:0]  inst_total_beats,
    input  logic [4:0]  inst_vreg_base,
    input  logic        ab_wb_vld,
    input  logic        ab_vld,
    input  logic [7:0]  ab_wb_bytes,
    input  logic [63:0] ab_wb_data,
    input  logic        lsu_abnormal_vld,
    input  logic        vrf_wb_ready,
    output logic        vrf_wb_vld,
    output logic [4:0]  vrf_wb_vreg,
    output logic        vrf_wb_half,
    output logic [7:0]  vrf_wb_bytes,
    output logic [63:0] vrf_wb_data,
    output logic        abnormal_ff,
    output logic        lsu_hold,
    output logic        ld_busy,
    output logic        ld_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [7:0]  beat_cnt_q, beat_cnt_d;
    logic [7:0]  total_q, total_d;
    logic [4:0]  base_q, base_d;
    logic        abn_q, abn_d;
    logic        hold_q, hold_d;
    logic        first_q, first_d;
    logic        acc_q, acc_d;
    logic [71:0] mem_q [3];

    logic        push;
    logic        pop;
    logic        force_push;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign vrf_wb_vld   = (cnt_q != 2'd0);
    assign {vrf_wb_bytes, vrf_wb_data} = mem_q[rd_ptr_q];
    assign vrf_wb_vreg  = base_q + beat_cnt_q[5:1];
    assign vrf_wb_half  = beat_cnt_q[0];
    assign abnormal_ff  = abn_q;
    assign lsu_hold     = hold_q;
    assign ld_busy      = (state_q != IDLE);
    assign ld_done      = (state_q == DONE);

    assign pop        = vrf_wb_vld && vrf_wb_ready;
    assign force_push = (state_q == DRAIN) && first_q && acc_q && ab_vld;
    assign push       = !rtu_yy_xx_flush &&
                        (((state_q == RUN) && ab_wb_vld) ||
                         ((state_q == DRAIN) && acc_q &&
                          (ab_wb_vld || force_push)));

    // Next-state, FIFO bookkeeping and flush override.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        beat_cnt_d = pop ? beat_cnt_q + 8'd1 : beat_cnt_q;
        total_d    = total_q;
        base_d     = base_q;
        abn_d      = abn_q;
        first_d    = 1'b0;
        acc_d      = acc_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        unique case (state_q)
            IDLE: begin
                if (inst_start) begin
                    state_d    = RUN;
                    total_d    = inst_total_beats;
                    base_d     = inst_vreg_base;
                    beat_cnt_d = 8'd0;
                end
            end
            RUN: begin
                if (lsu_abnormal_vld) begin
                    state_d = DRAIN;
                    abn_d   = 1'b1;
                    first_d = 1'b1;
                    acc_d   = 1'b1;
                end else if (beat_cnt_d == total_q && cnt_d == 2'd0) begin
                    state_d = DONE;
                end
            end
            DRAIN: begin
                if (force_push) acc_d = 1'b0;
                if (cnt_q == 2'd0 && !push) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                abn_d   = 1'b0;
                acc_d   = 1'b0;
            end
        endcase
        hold_d = (cnt_d >= 2'd2);
        if (rtu_yy_xx_flush) begin
            state_d    = IDLE;
            cnt_d      = 2'd0;
            wr_ptr_d   = 2'd0;
            rd_ptr_d   = 2'd0;
            beat_cnt_d = 8'd0;
            abn_d      = 1'b0;
            hold_d     = 1'b0;
            first_d    = 1'b0;
            acc_d      = 1'b0;
        end
    end

    // Control state register.
    always_ff @(posedge align_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            beat_cnt_q <= 8'd0;
            total_q    <= 8'd0;
            base_q     <= 5'd0;
            abn_q      <= 1'b0;
            hold_q     <= 1'b0;
            first_q    <= 1'b0;
            acc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            total_q    <= total_d;
            base_q     <= base_d;
            abn_q      <= abn_d;
            hold_q     <= hold_d;
            first_q    <= first_d;
            acc_q      <= acc_d;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge align_clk) begin
        if (push) mem_q[wr_ptr_q] <= {ab_wb_bytes, ab_wb_data};
    end

    a_no_overflow: assert property (
        @(posedge align_clk) disable iff (!cpurst_b)
        !(push && !pop && cnt_q == 2'd3));

endmodule

// File: tb/tb_aq_vlsu_ld_wb_sched.sv
// Scoreboard bench for aq_vlsu_ld_wb_sched: expected VRF writes are
// queued at stimulus time and popped by an independent monitor.
module tb_aq_vlsu_ld_wb_sched;

    logic        align_clk = 1'b0;
    logic        cpurst_b;
    logic        rtu_yy_xx_flush;
    logic        inst_start;
    logic [7:0]  inst_total_beats;
    logic [4:0]  inst_vreg_base;
    logic        ab_wb_vld;
    logic        ab_vld;
    logic [7:0]  ab_wb_bytes;
    logic [63:0] ab_wb_data;
    logic        lsu_abnormal_vld;
    logic        vrf_wb_ready;
    logic        vrf_wb_vld;
    logic [4:0]  vrf_wb_vreg;
    logic        vrf_wb_half;
    logic [7:0]  vrf_wb_bytes;
    logic [63:0] vrf_wb_data;
    logic        abnormal_ff;
    logic        lsu_hold;
    logic        ld_busy;
    logic        ld_done;

    aq_vlsu_ld_wb_sched dut (
        .align_clk        (align_clk),
        .cpurst_b         (cpurst_b),
        .rtu_yy_xx_flush  (rtu_yy_xx_flush),
        .inst_start       (inst_start),
        .inst_total_beats (inst_total_beats),
        .inst_vreg_base   (inst_vreg_base),
        .ab_wb_vld        (ab_wb_vld),
        .ab_vld           (ab_vld),
        .ab_wb_bytes      (ab_wb_bytes),
        .ab_wb_data       (ab_wb_data),
        .lsu_abnormal_vld (lsu_abnormal_vld),
        .vrf_wb_ready     (vrf_wb_ready),
        .vrf_wb_vld       (vrf_wb_vld),
        .vrf_wb_vreg      (vrf_wb_vreg),
        .vrf_wb_half      (vrf_wb_half),
        .vrf_wb_bytes     (vrf_wb_bytes),
        .vrf_wb_data      (vrf_wb_data),
        .abnormal_ff      (abnormal_ff),
        .lsu_hold         (lsu_hold),
        .ld_busy          (ld_busy),
        .ld_done          (ld_done)
    );

    always #5 align_clk = ~align_clk;

    typedef struct packed {
        logic [4:0]  vreg;
        logic        half;
        logic [7:0]  bytes;
        logic [63:0] data;
    } wb_t;

    wb_t exp_q[$];
    int  n_cmp  = 0;
    int  n_err  = 0;
    int  n_done = 0;
    bit  rnd_ready = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Beat k of a load lands in vreg base + k/2, half k%2.
    task automatic exp_add(input int base, input int idx,
                           input logic [7:0] by, input logic [63:0] d);
        wb_t e;
        e.vreg  = 5'((base + idx / 2) % 32);
        e.half  = 1'(idx % 2);
        e.bytes = by;
        e.data  = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted VRF write must match the queue head.
    always @(negedge align_clk) begin : mon
        wb_t got;
        wb_t e;
        if (ld_done) n_done++;
        if (vrf_wb_vld && vrf_wb_ready) begin
            got = {vrf_wb_vreg, vrf_wb_half, vrf_wb_bytes, vrf_wb_data};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL wb_unexpected: got %h want none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_err++;
                    $display("FAIL wb_data: got %h want %h", got, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge align_clk);
        #1;
        if (rnd_ready) vrf_wb_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic wait_done(input int d0);
        int g;
        g = 0;
        while (n_done == d0 && g < 3000) begin
            step();
            g++;
        end
        chk("done_pulses", 64'(n_done - d0), 64'd1);
        chk("busy_after", ld_busy, 1'b0);
        chk("abn_cleared", abnormal_ff, 1'b0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    // One load; abn_at < 0 means normal completion.
    task automatic run_txn(input int total, input int base, input int abn_at,
                           input bit partial, input logic [7:0] pb,
                           input bit dir);
        int          pushed;
        int          lim;
        int          g;
        int          d0;
        logic [7:0]  by;
        logic [63:0] dat;
        step();
        inst_start       = 1'b1;
        inst_total_beats = 8'(total);
        inst_vreg_base   = 5'(base);
        step();
        inst_start = 1'b0;
        chk("busy_run", ld_busy, 1'b1);
        d0     = n_done;
        lim    = (abn_at >= 0) ? abn_at : total;
        pushed = 0;
        g      = 0;
        while (pushed < lim && g < 4000) begin
            inst_start       = !dir && ($urandom_range(0, 7) == 0);
            inst_total_beats = 8'($urandom_range(1, 128));
            if (!lsu_hold && (dir || $urandom_range(0, 3) != 0)) begin
                by  = dir ? 8'hFF : 8'($urandom);
                dat = {$urandom, $urandom};
                ab_wb_vld   = 1'b1;
                ab_wb_bytes = by;
                ab_wb_data  = dat;
                exp_add(base, pushed, by, dat);
                pushed++;
            end else begin
                ab_wb_vld = 1'b0;
            end
            step();
            g++;
        end
        inst_start = 1'b0;
        ab_wb_vld  = 1'b0;
        if (abn_at >= 0) begin
            dat              = {$urandom, $urandom};
            lsu_abnormal_vld = 1'b1;
            ab_vld           = partial;
            ab_wb_bytes      = pb;
            ab_wb_data       = dat;
            step();
            lsu_abnormal_vld = 1'b0;
            chk("abn_ff_set", abnormal_ff, 1'b1);
            if (partial) exp_add(base, pushed, pb, dat);
            step();
            ab_vld = 1'b0;
        end
        wait_done(d0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        int d0;
        int tot;
        int abn;
        cpurst_b         = 1'b0;
        rtu_yy_xx_flush  = 1'b0;
        inst_start       = 1'b0;
        inst_total_beats = 8'd0;
        inst_vreg_base   = 5'd0;
        ab_wb_vld        = 1'b0;
        ab_vld           = 1'b0;
        ab_wb_bytes      = 8'd0;
        ab_wb_data       = 64'd0;
        lsu_abnormal_vld = 1'b0;
        vrf_wb_ready     = 1'b1;
        #2;
        chk("rst_vld", vrf_wb_vld, 1'b0);
        chk("rst_busy", ld_busy, 1'b0);
        chk("rst_done", ld_done, 1'b0);
        chk("rst_hold", lsu_hold, 1'b0);
        chk("rst_abn", abnormal_ff, 1'b0);
        step();
        cpurst_b = 1'b1;
        step();

        // Back-to-back beats, then the vreg-wrap case.
        run_txn(4, 8, -1, 1'b0, 8'h00, 1'b1);
        run_txn(4, 31, -1, 1'b0, 8'h00, 1'b1);

        // Abnormal after one beat with a partial beat pending.
        run_txn(4, 5, 1, 1'b1, 8'h0F, 1'b1);

        // Stalled VRF port: three beats fill the FIFO.
        vrf_wb_ready = 1'b0;
        step();
        inst_start       = 1'b1;
        inst_total_beats = 8'd3;
        inst_vreg_base   = 5'd4;
        step();
        inst_start = 1'b0;
        d0 = n_done;
        for (int i = 0; i < 3; i++) begin
            ab_wb_vld   = 1'b1;
            ab_wb_bytes = 8'hFF;
            ab_wb_data  = 64'hA5A5_0000_0000_0000 | 64'(i);
            exp_add(4, i, 8'hFF, ab_wb_data);
            step();
            chk("hold_fill", lsu_hold, (i >= 1) ? 1'b1 : 1'b0);
        end
        ab_wb_vld = 1'b0;
        chk("full_vld", vrf_wb_vld, 1'b1);
        vrf_wb_ready = 1'b1;
        wait_done(d0);

        // Flush with two beats queued; same-cycle start is dropped.
        vrf_wb_ready = 1'b0;
        step();
        inst_start       = 1'b1;
        inst_total_beats = 8'd8;
        inst_vreg_base   = 5'd3;
        step();
        inst_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ab_wb_vld  = 1'b1;
            ab_wb_data = {$urandom, $urandom};
            step();
        end
        ab_wb_vld = 1'b0;
        chk("hold_pre_flush", lsu_hold, 1'b1);
        d0 = n_done;
        rtu_yy_xx_flush = 1'b1;
        inst_start      = 1'b1;
        step();
        rtu_yy_xx_flush = 1'b0;
        inst_start      = 1'b0;
        chk("flush_vld", vrf_wb_vld, 1'b0);
        chk("flush_busy", ld_busy, 1'b0);
        chk("flush_hold", lsu_hold, 1'b0);
        step();
        step();
        chk("flush_no_done", 64'(n_done - d0), 64'd0);
        chk("flush_idle", ld_busy, 1'b0);
        vrf_wb_ready = 1'b1;
        run_txn(3, 20, -1, 1'b0, 8'h00, 1'b1);

        // Reset while stuck in DRAIN.
        vrf_wb_ready = 1'b0;
        step();
        inst_start       = 1'b1;
        inst_total_beats = 8'd4;
        step();
        inst_start = 1'b0;
        ab_wb_vld  = 1'b1;
        step();
        ab_wb_vld        = 1'b0;
        lsu_abnormal_vld = 1'b1;
        step();
        lsu_abnormal_vld = 1'b0;
        step();
        chk("drain_busy", ld_busy, 1'b1);
        d0 = n_done;
        cpurst_b = 1'b0;
        #1;
        chk("arst_vld", vrf_wb_vld, 1'b0);
        chk("arst_busy", ld_busy, 1'b0);
        chk("arst_abn", abnormal_ff, 1'b0);
        chk("arst_hold", lsu_hold, 1'b0);
        exp_q.delete();
        step();
        cpurst_b     = 1'b1;
        vrf_wb_ready = 1'b1;
        step();
        step();
        chk("arst_idle", ld_busy, 1'b0);
        chk("arst_no_done", 64'(n_done - d0), 64'd0);

        // Randomized loads with random VRF backpressure.
        rnd_ready = 1'b1;
        for (int t = 0; t < 25; t++) begin
            tot = $urandom_range(1, 10);
            abn = ($urandom_range(0, 2) == 0) ? $urandom_range(0, tot - 1) : -1;
            run_txn(tot, $urandom_range(0, 31), abn, 1'($urandom),
                    8'($urandom_range(1, 255)), 1'b0);
        end
        rnd_ready = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/aq_vlsu_ld_wb_sched.md
AQ_VLSU_LD_WB_SCHED -- requirements
Module: aq_vlsu_ld_wb_sched

Interface
REQ-001 SHALL have a single clock and reset: clock align_clk; reset cpurst_b, asynchronous, active-low.
REQ-002 Ports, listed as name, direction, width, meaning:
- align_clk  in  1  gated clock shared with the load align buffer
- cpurst_b  in  1  async active-low reset
- rtu_yy_xx_flush  in  1  pipeline flush
- inst_start  in  1  one-cycle pulse that starts a vector load
- inst_total_beats  in  8  64-bit beats expected (1..128), sampled on inst_start
- inst_vreg_base  in  5  first destination vreg, sampled on inst_start
- ab_wb_vld  in  1  align buffer has a full 8-byte beat ready
- ab_vld  in  1  align buffer holds partial bytes
- ab_wb_bytes  in  8  byte enables of the presented beat
- ab_wb_data  in  64  beat data
- lsu_abnormal_vld  in  1  exception or vl-update (fault-only-first) terminates the load
- vrf_wb_ready  in  1  VRF write port grant
- vrf_wb_vld  out  1  VRF write request
- vrf_wb_vreg  out  5  destination vreg
- vrf_wb_half  out  1  0 = bits 63:0, 1 = bits 127:64 of the vreg
- vrf_wb_bytes  out  8  byte write enables
- vrf_wb_data  out  64  write data
- abnormal_ff  out  1  abnormal-termination flag to the align buffer
- lsu_hold  out  1  backpressure to the LSU data return
- ld_busy  out  1  state != IDLE
- ld_done  out  1  one-cycle completion pulse

Function
REQ-003 States SHALL be IDLE, RUN, DRAIN and DONE.
- IDLE->RUN on inst_start.
- RUN->DONE when the popped-beat count reaches inst_total_beats and the FIFO is empty.
- RUN->DRAIN on lsu_abnormal_vld.
- DRAIN->DONE when the FIFO is empty and no partial beat is pending.
- DONE->IDLE unconditionally after 1 cycle.
REQ-004 The block SHALL contain a 3-entry FIFO of {bytes[7:0], data[63:0]} with 2-bit rd/wr pointers wrapping 2->0 and a 2-bit count.
REQ-005 In RUN, ab_wb_vld SHALL push {ab_wb_bytes, ab_wb_data}; a push with count==3 is illegal and SHALL be flagged by an assertion.
REQ-006 lsu_hold SHALL be registered and equal 1 in the cycle after the post-update count becomes >=2.
REQ-007 vrf_wb_vld SHALL equal (count!=0) with the head entry driven on vrf_wb_bytes and vrf_wb_data; a pop occurs on vrf_wb_vld && vrf_wb_ready.
REQ-008 A push and a pop in the same cycle SHALL leave the count unchanged; a push at count 3 that coincides with a pop is legal.
REQ-009 The 8-bit beat_cnt SHALL clear on inst_start and increment on each pop.
- vrf_wb_vreg = inst_vreg_base + beat_cnt[7:1], mod 32.
- vrf_wb_half = beat_cnt[0].
REQ-010 On lsu_abnormal_vld in RUN, abnormal_ff SHALL set on the next edge and stay set until IDLE.
REQ-011 In the first DRAIN cycle, if ab_vld=1 the block SHALL push exactly one entry {ab_wb_bytes, ab_wb_data} carrying the partial byte enables.
REQ-012 In DRAIN, ab_wb_vld SHALL still be accepted for beats already in flight; no beats are accepted after the forced partial push.
REQ-013 ld_done SHALL be high exactly in the DONE state; ld_busy = (state!=IDLE).
REQ-014 inst_start outside IDLE SHALL be ignored.
REQ-015 lsu_abnormal_vld in IDLE or DONE SHALL be ignored.
REQ-016 Simultaneous last pop and lsu_abnormal_vld SHALL take RUN->DRAIN, with DRAIN completing immediately if nothing is pending.
REQ-017 rtu_yy_xx_flush SHALL have priority over all other events. In any state it SHALL, on the next edge:
- return to IDLE;
- clear the count, pointers, beat_cnt, abnormal_ff and lsu_hold;
- suppress ld_done.
A same-cycle inst_start is dropped.

Reset
REQ-018 On cpurst_b low, outputs SHALL be:
- state IDLE;
- vrf_wb_vld=0, lsu_hold=0, abnormal_ff=0, ld_busy=0, ld_done=0;
- count=0, pointers=0, beat_cnt=0.
FIFO data SHALL not be reset.
REQ-019 Reset asserted mid-operation SHALL abort with no VRF write and no ld_done; operation resumes only on a new inst_start after release.

Verification
REQ-020 Scenario: inst_start with total_beats=4, base=8, ready=1, 4 back-to-back ab_wb_vld -> writes vreg/half 8/0, 8/1, 9/0, 9/1, bytes 0xFF, then one ld_done pulse.
REQ-021 Scenario: vrf_wb_ready=0 while 3 beats arrive -> lsu_hold=1 after the count reaches 2, no overflow assertion; ready=1 -> 3 writes in order.
REQ-022 Scenario: base=31, total_beats=4 -> vregs 31, 31, 0, 0 (wrap).
REQ-023 Scenario: after 1 beat, lsu_abnormal_vld with ab_vld=1, ab_wb_bytes=0x0F -> abnormal_ff=1, second write has bytes 0x0F, then ld_done.
REQ-024 Scenario: flush with count=2 in RUN -> next cycle vrf_wb_vld=0, ld_busy=0, no ld_done; a subsequent inst_start runs normally.
REQ-025 Scenario: cpurst_b low during DRAIN -> all outputs at reset values; state IDLE after release.
